// File: rtl/opcode_fetcher.sv
// Purpose : fetches one opcode per trigger from a synchronous-read memory once it is ready.
// Latency : trigger sampled at T -> mem_rd_en at T+1 -> opcode/opcode_valid at T+3.
// Backpres: none; a trigger that lands while a fetch is in flight is dropped and flagged in overrun.
//
// Ports:
//   clk          system clock, all state on rising edge
//   rst          asynchronous active-low reset
//   ready        memory contents valid (level)
//   trigger      one-cycle fetch request
//   load         synchronous restart of the address pointer (and overrun clear)
//   mem_rd_en    memory read enable, one cycle per fetch
//   mem_addr     memory read address, held between fetches
//   mem_rdata    memory read data, valid the cycle after mem_rd_en
//   opcode       last fetched opcode, held between fetches
//   opcode_valid one-cycle strobe when opcode is updated
//   overrun      sticky flag: trigger arrived while a fetch was in flight
module opcode_fetcher #(
  parameter int MAX_ADDR = 3,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  input  logic              trigger,
  input  logic              load,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] opcode,
  output logic              opcode_valid,
  output logic              overrun
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_READ    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  // Remembers a load seen during READ so the following CAPTURE leaves the
  // pointer at 0 instead of advancing past the address just fetched.
  logic              skip_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      skip_inc     <= 1'b0;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      opcode       <= '0;
      opcode_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // Both strobes are single-cycle; only the states below raise them.
      mem_rd_en    <= 1'b0;
      opcode_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Triggers are ignored here and never count as overrun.
          if (load) begin
            ptr     <= '0;
            overrun <= 1'b0;
          end
          if (ready) begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (load) begin
            ptr     <= '0;
            overrun <= 1'b0;
          end
          // Losing ready wins over a same-cycle trigger.
          if (!ready) begin
            state <= ST_IDLE;
          end else if (trigger) begin
            state     <= ST_READ;
            mem_rd_en <= 1'b1;
            // A same-cycle load restarts at address 0 for this very fetch.
            mem_addr  <= load ? '0 : ptr;
          end
        end

        ST_READ: begin
          // The memory samples mem_addr at the end of this cycle.
          if (trigger) begin
            overrun <= 1'b1;
          end
          if (load) begin
            ptr      <= '0;
            overrun  <= 1'b0;
            skip_inc <= 1'b1;
          end
          state <= ST_CAPTURE;
        end

        ST_CAPTURE: begin
          opcode       <= mem_rdata;
          opcode_valid <= 1'b1;
          if (trigger) begin
            overrun <= 1'b1;
          end
          if (load) begin
            overrun <= 1'b0;
          end
          if (load || skip_inc) begin
            ptr <= '0;
          end else if (ptr == LAST_ADDR) begin
            ptr <= '0;
          end else begin
            ptr <= ptr + ADDR_ONE;
          end
          skip_inc <= 1'b0;
          // Always return to WAIT; WAIT itself drops to IDLE if ready fell.
          state    <= ST_WAIT;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opcode_fetcher.sv
// Purpose : self-checking bench for opcode_fetcher (vector table, directed corners, random vs model).
// Latency : n/a.
// Backpres: n/a.
module tb_opcode_fetcher;

  localparam int MAX_ADDR = 3;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 8;

  logic              clk;
  logic              rst;
  logic              ready;
  logic              trigger;
  logic              load;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] opcode;
  logic              opcode_valid;
  logic              overrun;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] mem [256];

  opcode_fetcher #(.MAX_ADDR(MAX_ADDR), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ready        (ready),
    .trigger      (trigger),
    .load         (load),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .opcode       (opcode),
    .opcode_valid (opcode_valid),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h required %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string name, input logic rd, input logic [7:0] a,
                         input logic [7:0] op, input logic v, input logic ov);
    chk1({name, ".mem_rd_en"}, mem_rd_en, rd);
    chk8({name, ".mem_addr"}, mem_addr, a);
    chk8({name, ".opcode"}, opcode, op);
    chk1({name, ".opcode_valid"}, opcode_valid, v);
    chk1({name, ".overrun"}, overrun, ov);
  endtask

  // One full fetch: trigger, then check the read cycle, the 3-cycle strobe,
  // and that each strobe lasts one cycle. Occupies 10 cycles in total.
  task automatic do_fetch(input logic [7:0] ea, input logic [7:0] eo);
    trigger = 1'b1;
    step;
    trigger = 1'b0;
    chk1("fetch.rd_en", mem_rd_en, 1'b1);
    chk8("fetch.addr", mem_addr, ea);
    step;
    chk1("fetch.rd_en_single", mem_rd_en, 1'b0);
    chk1("fetch.valid_early", opcode_valid, 1'b0);
    step;
    chk1("fetch.valid", opcode_valid, 1'b1);
    chk8("fetch.opcode", opcode, eo);
    step;
    chk1("fetch.valid_single", opcode_valid, 1'b0);
    repeat (6) step;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] in_rtl;   // {ready, trigger, load}
    logic       rd;
    logic [7:0] addr;
    logic [7:0] op;
    logic       v;
    logic       ov;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic [2:0] i, input logic rd, input logic [7:0] a,
                              input logic [7:0] op, input logic v, input logic ov);
    vec_t r;
    r.in_rtl = i; r.rd = rd; r.addr = a; r.op = op; r.v = v; r.ov = ov;
    return r;
  endfunction

  // ---------------- reference model ----------------
  // Time-based view: a fetch accepted at cycle c owns cycles c+1 and c+2;
  // its opcode is reported after cycle c+2. Triggers inside that window overrun.
  int          m_cyc;
  int          m_acc;
  bit          m_armed;
  int          m_ptr;
  int          m_faddr;
  bit          m_skip;
  logic        m_ovr;
  logic [7:0]  m_op;
  logic        m_rd;
  logic [7:0]  m_addr;
  logic        m_v;

  task automatic model_reset;
    m_cyc = 0; m_acc = -100; m_armed = 1'b0; m_ptr = 0; m_faddr = 0; m_skip = 1'b0;
    m_ovr = 1'b0; m_op = 8'h00; m_rd = 1'b0; m_addr = 8'h00; m_v = 1'b0;
  endtask

  task automatic model_edge(input logic r, input logic t, input logic l);
    bit in_flight;
    bit last_cycle;
    in_flight  = (m_cyc == m_acc + 1) || (m_cyc == m_acc + 2);
    last_cycle = (m_cyc == m_acc + 2);
    m_rd = 1'b0;
    m_v  = 1'b0;
    if (in_flight) begin
      if (t) m_ovr = 1'b1;
      if (l) begin m_ovr = 1'b0; m_skip = 1'b1; end
      if (last_cycle) begin
        m_op   = mem[m_faddr];
        m_v    = 1'b1;
        m_ptr  = m_skip ? 0 : (m_ptr + 1) % (MAX_ADDR + 1);
        m_skip = 1'b0;
      end
    end else begin
      if (l) begin m_ptr = 0; m_ovr = 1'b0; end
      if (!m_armed) begin
        if (r) m_armed = 1'b1;
      end else if (!r) begin
        m_armed = 1'b0;
      end else if (t) begin
        m_faddr = m_ptr;
        m_addr  = 8'(m_ptr);
        m_rd    = 1'b1;
        m_acc   = m_cyc;
      end
    end
    m_cyc++;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic r_cur;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

    tbl[0]  = mk(3'b110, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0); // IDLE->WAIT, trigger ignored
    tbl[1]  = mk(3'b110, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0); // accept addr 0
    tbl[2]  = mk(3'b100, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tbl[3]  = mk(3'b100, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0); // strobe
    tbl[4]  = mk(3'b110, 1'b1, 8'h01, 8'h11, 1'b0, 1'b0); // accept addr 1
    tbl[5]  = mk(3'b110, 1'b0, 8'h01, 8'h11, 1'b0, 1'b1); // trigger in READ -> overrun
    tbl[6]  = mk(3'b100, 1'b0, 8'h01, 8'h22, 1'b1, 1'b1);
    tbl[7]  = mk(3'b110, 1'b1, 8'h02, 8'h22, 1'b0, 1'b1); // back-to-back at 3-cycle spacing
    tbl[8]  = mk(3'b100, 1'b0, 8'h02, 8'h22, 1'b0, 1'b1);
    tbl[9]  = mk(3'b110, 1'b0, 8'h02, 8'h33, 1'b1, 1'b1); // trigger in CAPTURE
    tbl[10] = mk(3'b111, 1'b1, 8'h00, 8'h33, 1'b0, 1'b0); // load+trigger -> addr 0
    tbl[11] = mk(3'b100, 1'b0, 8'h00, 8'h33, 1'b0, 1'b0);
    tbl[12] = mk(3'b100, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0);
    tbl[13] = mk(3'b010, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0); // ready low wins over trigger
    tbl[14] = mk(3'b010, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0); // IDLE ignores trigger
    tbl[15] = mk(3'b110, 1'b0, 8'h00, 8'h11, 1'b0, 1'b0); // ready rise, trigger ignored
    tbl[16] = mk(3'b110, 1'b1, 8'h01, 8'h11, 1'b0, 1'b0); // accept addr 1
    tbl[17] = mk(3'b101, 1'b0, 8'h01, 8'h11, 1'b0, 1'b0); // load during READ
    tbl[18] = mk(3'b000, 1'b0, 8'h01, 8'h22, 1'b1, 1'b0); // ready drops in CAPTURE, still strobes
    tbl[19] = mk(3'b010, 1'b0, 8'h01, 8'h22, 1'b0, 1'b0); // WAIT->IDLE, trigger ignored
    tbl[20] = mk(3'b100, 1'b0, 8'h01, 8'h22, 1'b0, 1'b0);
    tbl[21] = mk(3'b110, 1'b1, 8'h00, 8'h22, 1'b0, 1'b0); // pointer stayed 0 after load
    tbl[22] = mk(3'b100, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0);
    tbl[23] = mk(3'b100, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0);

    // Reset state, checked while reset is held.
    rst = 1'b0; ready = 1'b0; trigger = 1'b0; load = 1'b0;
    #3;
    chk_all("reset", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) step;
    rst = 1'b1;

    // Not ready: periodic triggers must be ignored entirely.
    for (int i = 0; i < 30; i++) begin
      trigger = (i % 10 == 0);
      step;
      chk1("idle.rd_en", mem_rd_en, 1'b0);
      chk1("idle.valid", opcode_valid, 1'b0);
    end
    trigger = 1'b0;
    chk8("idle.opcode", opcode, 8'h00);
    chk1("idle.overrun", overrun, 1'b0);

    // Vector table.
    for (int i = 0; i < 24; i++) begin
      {ready, trigger, load} = tbl[i].in_rtl;
      step;
      chk_all($sformatf("vec%0d", i), tbl[i].rd, tbl[i].addr, tbl[i].op, tbl[i].v, tbl[i].ov);
    end
    trigger = 1'b0; load = 1'b0; ready = 1'b1;

    // Sequential fetches through the wrap (pointer is at 1 here).
    do_fetch(8'h01, 8'h22);
    do_fetch(8'h02, 8'h33);
    do_fetch(8'h03, 8'h44);
    do_fetch(8'h00, 8'h11);
    do_fetch(8'h01, 8'h22);

    // Overrun: trigger at T and T+2, then T+3 accepted normally.
    trigger = 1'b1; step;                 // T accepted, addr 2
    trigger = 1'b0; step;                 // T+1 (READ)
    trigger = 1'b1; step;                 // T+2 (CAPTURE) dropped
    chk1("ovr.valid", opcode_valid, 1'b1);
    chk8("ovr.opcode", opcode, 8'h33);
    chk1("ovr.flag", overrun, 1'b1);
    trigger = 1'b1; step;                 // T+3 accepted, addr 3
    trigger = 1'b0;
    chk1("ovr.next_rd", mem_rd_en, 1'b1);
    chk8("ovr.next_addr", mem_addr, 8'h03);
    chk1("ovr.held", overrun, 1'b1);
    step; step;
    chk8("ovr.next_opcode", opcode, 8'h44);
    repeat (5) step;
    chk1("ovr.sticky", overrun, 1'b1);

    // Load with nothing in flight restarts at address 0 and clears overrun.
    load = 1'b1; step; load = 1'b0;
    chk1("load.ovr_clr", overrun, 1'b0);
    repeat (3) step;
    do_fetch(8'h00, 8'h11);

    // Async reset in the middle of a fetch (with overrun and opcode set first).
    trigger = 1'b1; step;                 // accept addr 1
    trigger = 1'b1; step;                 // READ: overrun
    trigger = 1'b0; repeat (4) step;
    chk1("arst.pre_ovr", overrun, 1'b1);
    trigger = 1'b1; step;                 // accept addr 2, now in READ
    trigger = 1'b0;
    chk1("arst.pre_rd", mem_rd_en, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_all("arst", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step; step;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step;
      chk1("arst.no_strobe", opcode_valid, 1'b0);
    end
    do_fetch(8'h00, 8'h11);

    // Random stimulus against the reference model.
    for (int i = 0; i < 4; i++) mem[i] = 8'($urandom);
    rst = 1'b0; ready = 1'b0; trigger = 1'b0; load = 1'b0;
    step;
    rst = 1'b1;
    model_reset();
    r_cur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) r_cur = ~r_cur;
      ready   = r_cur;
      trigger = ($urandom_range(0, 99) < 25);
      load    = ($urandom_range(0, 99) < 3);
      step;
      model_edge(ready, trigger, load);
      chk_all("rand", m_rd, m_addr, m_op, m_v, m_ovr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
